elevator_scan_ctrl: RTL and testbench

Next-generation single-car elevator controller with a NUM_FLOORS parameter, separate car, hall-up and hall-down request banks, and per-direction request clearing.

---
 rtl/elevator_pkg.sv | 22 ++
 rtl/elevator_req_bank.sv | 68 ++++++
 rtl/elevator_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types for the LOOK-scan elevator controller:
// controller states plus door_state / move_dir encodings.
package elevator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    DOOR_OPENING,
    DOOR_HOLD,
    DOOR_CLOSING
  } state_t;

  localparam logic [1:0] DOOR_CLOSED    = 2'b00;
  localparam logic [1:0] DOOR_OPENING_E = 2'b01;
  localparam logic [1:0] DOOR_OPEN      = 2'b10;
  localparam logic [1:0] DOOR_CLOSING_E = 2'b11;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

// File: rtl/elevator_req_bank.sv
// Car / hall-up / hall-down request latches with clear priority,
// plus ahead/behind/here queries for one floor and direction.
module elevator_req_bank
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_down_req,
  input  logic [NUM_FLOORS-1:0] clr_car,
  input  logic [NUM_FLOORS-1:0] clr_up,
  input  logic [NUM_FLOORS-1:0] clr_down,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pend_car,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_down,
  output logic                  any_ahead,
  output logic                  any_behind,
  output logic                  here_car,
  output logic                  here_up,
  output logic                  here_down
);

  logic [NUM_FLOORS-1:0] up_m;
  logic [NUM_FLOORS-1:0] dn_m;
  logic [NUM_FLOORS-1:0] above;
  logic [NUM_FLOORS-1:0] below;
  logic [NUM_FLOORS-1:0] any;

  // no up call from the top floor, no down call from the bottom
  always_comb begin
    up_m = hall_up_req;
    up_m[NUM_FLOORS-1] = 1'b0;
    dn_m = hall_down_req;
    dn_m[0] = 1'b0;
    above = '0;
    below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above[i] = i > int'(floor);
      below[i] = i < int'(floor);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_car  <= '0;
      pend_up   <= '0;
      pend_down <= '0;
    end else begin
      pend_car  <= (pend_car | car_req) & ~clr_car;
      pend_up   <= (pend_up | up_m) & ~clr_up;
      pend_down <= (pend_down | dn_m) & ~clr_down;
    end
  end

  assign any        = pend_car | pend_up | pend_down;
  assign any_ahead  = |(any & (dir_up ? above : below));
  assign any_behind = |(any & (dir_up ? below : above));
  assign here_car   = pend_car[floor];
  assign here_up    = pend_up[floor];
  assign here_down  = pend_down[floor];

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car LOOK/collective scan controller with door sequencing.
// Optional idle parking enabled by defining ELEV_PARK_EN.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = 8,
  parameter int TIMER_W         = 8,
  parameter int TIME_MOVE       = 5,
  parameter int TIME_DOOR_OPEN  = 5,
  parameter int TIME_DOOR_HOLD  = 5,
  parameter int TIME_DOOR_CLOSE = 5,
`ifdef ELEV_PARK_EN
  parameter int PARK_FLOOR      = 0,
  parameter int PARK_TIMEOUT    = 50,
`endif
  localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_down_req,
  input  logic                  door_reopen,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [1:0]            door_state,
  output logic [1:0]            move_dir,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pend_car,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_down,
  output logic                  arrive
);

  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [TIMER_W-1:0] T_MOVE  = TIMER_W'(TIME_MOVE);
  localparam logic [TIMER_W-1:0] T_OPEN  = TIMER_W'(TIME_DOOR_OPEN);
  localparam logic [TIMER_W-1:0] T_HOLD  = TIMER_W'(TIME_DOOR_HOLD);
  localparam logic [TIMER_W-1:0] T_CLOSE = TIMER_W'(TIME_DOOR_CLOSE);

  state_t state;
  state_t state_n;

  logic [TIMER_W-1:0]    timer;
  logic [TIMER_W-1:0]    timer_n;
  logic [FLOOR_W-1:0]    floor_n;
  logic [FLOOR_W-1:0]    nf;
  logic [FLOOR_W-1:0]    q;
  logic [NUM_FLOORS-1:0] q_oh;
  logic [NUM_FLOORS-1:0] clr_car;
  logic [NUM_FLOORS-1:0] clr_up;
  logic [NUM_FLOORS-1:0] clr_down;

  logic dir_n;
  logic arrive_n;
  logic open_go;
  logic t_one;
  logic travel;
  logic opp;
  logic stop;
  logic serve_keep;
  logic served;
  logic new_here;
  logic here_any;
  logic any_ahead;
  logic any_behind;
  logic here_car;
  logic here_up;
  logic here_down;

`ifdef ELEV_PARK_EN
  localparam logic [FLOOR_W-1:0] PF = FLOOR_W'(PARK_FLOOR);
  logic        park;
  logic        park_n;
  logic        park_eff;
  logic [15:0] idle_cnt;
  logic [15:0] idle_cnt_n;
`endif

  // while moving, queries look at the floor about to be reached
  always_comb begin
    nf = current_floor;
    if (dir_up && current_floor != TOP)
      nf = current_floor + FLOOR_W'(1);
    else if (!dir_up && current_floor != '0)
      nf = current_floor - FLOOR_W'(1);
    q = (state == MOVE) ? nf : current_floor;
    q_oh = '0;
    q_oh[q] = 1'b1;
  end

  elevator_req_bank #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_bank (
    .clk           (clk),
    .rst           (rst),
    .car_req       (car_req),
    .hall_up_req   (hall_up_req),
    .hall_down_req (hall_down_req),
    .clr_car       (clr_car),
    .clr_up        (clr_up),
    .clr_down      (clr_down),
    .floor         (q),
    .dir_up        (dir_up),
    .pend_car      (pend_car),
    .pend_up       (pend_up),
    .pend_down     (pend_down),
    .any_ahead     (any_ahead),
    .any_behind    (any_behind),
    .here_car      (here_car),
    .here_up       (here_up),
    .here_down     (here_down)
  );

  always_comb begin
    t_one      = timer == TIMER_W'(1);
    travel     = dir_up ? here_up : here_down;
    opp        = dir_up ? here_down : here_up;
    here_any   = here_car | here_up | here_down;
    stop       = here_car | travel | (~any_ahead & opp);
    // keep the travel direction only if it still has work
    serve_keep = any_ahead | (travel & ~opp);
    served     = serve_keep ? dir_up : ~dir_up;
    new_here   = door_reopen | car_req[current_floor] |
                 (dir_up ? (hall_up_req[current_floor] && current_floor != TOP)
                         : (hall_down_req[current_floor] && current_floor != '0));

    state_n  = state;
    timer_n  = timer;
    floor_n  = current_floor;
    dir_n    = dir_up;
    arrive_n = 1'b0;
    open_go  = 1'b0;
    clr_car  = '0;
    clr_up   = '0;
    clr_down = '0;
`ifdef ELEV_PARK_EN
    park_eff   = park & ~(|{pend_car, pend_up, pend_down});
    park_n     = park_eff;
    idle_cnt_n = '0;
`endif

    unique case (state)
      IDLE: begin
        if (here_any) begin
          open_go = 1'b1;
        end else if (any_ahead) begin
          state_n = MOVE;
          timer_n = T_MOVE;
        end else if (any_behind) begin
          dir_n   = ~dir_up;
          state_n = MOVE;
          timer_n = T_MOVE;
        end
`ifdef ELEV_PARK_EN
        else if (current_floor != PF) begin
          if (idle_cnt == 16'(PARK_TIMEOUT - 1)) begin
            dir_n   = PF > current_floor;
            state_n = MOVE;
            timer_n = T_MOVE;
            park_n  = 1'b1;
          end else begin
            idle_cnt_n = idle_cnt + 16'd1;
          end
        end
`endif
      end
      MOVE: begin
        if (t_one) begin
          floor_n = nf;
`ifdef ELEV_PARK_EN
          if (park_eff) begin
            if (nf == PF) begin
              state_n = IDLE;
              timer_n = '0;
            end else begin
              timer_n = T_MOVE;
            end
          end else
`endif
          if (stop) begin
            open_go  = 1'b1;
            arrive_n = 1'b1;
          end else if (!any_ahead) begin
            state_n = IDLE;
            timer_n = '0;
          end else begin
            timer_n = T_MOVE;
          end
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      DOOR_OPENING: begin
        if (t_one) begin
          state_n = DOOR_HOLD;
          timer_n = T_HOLD;
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      DOOR_HOLD: begin
        clr_car = q_oh;
        if (dir_up) clr_up = q_oh;
        else        clr_down = q_oh;
        if (new_here) begin
          timer_n = T_HOLD;
        end else if (t_one) begin
          state_n = DOOR_CLOSING;
          timer_n = T_CLOSE;
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      DOOR_CLOSING: begin
        if (door_reopen) begin
          state_n = DOOR_OPENING;
          timer_n = T_OPEN;
        end else if (t_one) begin
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase

    if (open_go) begin
      state_n = DOOR_OPENING;
      timer_n = T_OPEN;
      dir_n   = served;
      clr_car = q_oh;
      if (served) clr_up = q_oh;
      else        clr_down = q_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      current_floor <= '0;
      dir_up        <= 1'b1;
      arrive        <= 1'b0;
`ifdef ELEV_PARK_EN
      park          <= 1'b0;
      idle_cnt      <= '0;
`endif
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      current_floor <= floor_n;
      dir_up        <= dir_n;
      arrive        <= arrive_n;
`ifdef ELEV_PARK_EN
      park          <= park_n;
      idle_cnt      <= idle_cnt_n;
`endif
    end
  end

  always_comb begin
    door_state = DOOR_CLOSED;
    move_dir   = DIR_IDLE;
    unique case (state)
      MOVE:         move_dir   = dir_up ? DIR_UP : DIR_DOWN;
      DOOR_OPENING: door_state = DOOR_OPENING_E;
      DOOR_HOLD:    door_state = DOOR_OPEN;
      DOOR_CLOSING: door_state = DOOR_CLOSING_E;
      default:      door_state = DOOR_CLOSED;
    endcase
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: per-cycle vector table
// plus hand sequences for scan stops, reversal and mid-move reset.
module tb_elevator_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] car_req;
  logic [7:0] hall_up_req;
  logic [7:0] hall_down_req;
  logic       door_reopen;
  logic [2:0] current_floor;
  logic [1:0] door_state;
  logic [1:0] move_dir;
  logic       dir_up;
  logic [7:0] pend_car;
  logic [7:0] pend_up;
  logic [7:0] pend_down;
  logic       arrive;

  int nvec;
  int nerr;

  elevator_scan_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .car_req       (car_req),
    .hall_up_req   (hall_up_req),
    .hall_down_req (hall_down_req),
    .door_reopen   (door_reopen),
    .current_floor (current_floor),
    .door_state    (door_state),
    .move_dir      (move_dir),
    .dir_up        (dir_up),
    .pend_car      (pend_car),
    .pend_up       (pend_up),
    .pend_down     (pend_down),
    .arrive        (arrive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] car;
    logic [7:0] up;
    logic [7:0] dn;
    logic       ro;
    int         n;
    logic [2:0] fl;
    logic [1:0] door;
    logic [1:0] mdir;
    logic       arr;
    logic       dir;
    logic [7:0] pc;
    logic [7:0] pu;
    logic [7:0] pd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] c, input logic [7:0] u,
                     input logic [7:0] d, input logic ro, input int n,
                     input logic [2:0] fl, input logic [1:0] door,
                     input logic [1:0] mdir, input logic arr, input logic dir,
                     input logic [7:0] pc, input logic [7:0] pu,
                     input logic [7:0] pd);
    vec_t v;
    v.rst = r; v.car = c; v.up = u; v.dn = d; v.ro = ro; v.n = n;
    v.fl = fl; v.door = door; v.mdir = mdir; v.arr = arr; v.dir = dir;
    v.pc = pc; v.pu = pu; v.pd = pd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_floor(input logic [2:0] f, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (current_floor == f) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_arrive(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (arrive) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  bit ok;

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    car_req = '0;
    hall_up_req = '0;
    hall_down_req = '0;
    door_reopen = 1'b0;

    // car call to floor 3 from reset
    //  r  car    up     dn     ro n  fl dr md ar dir pc     pu     pd
    add(1, 8'h00, 8'h00, 8'h00, 0, 2, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    add(0, 8'h08, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h08, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 5, 0, 0, 1, 0, 1, 8'h08, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 5, 1, 0, 1, 0, 1, 8'h08, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 5, 2, 0, 1, 0, 1, 8'h08, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 1, 3, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 4, 3, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 5, 3, 2, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 5, 3, 3, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 3, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    // ignored hall bits, then a hall call at the current floor
    add(0, 8'h00, 8'h80, 8'h01, 0, 2, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h08, 0, 1, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h08);
    add(0, 8'h00, 8'h00, 8'h00, 0, 1, 3, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 4, 3, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 5, 3, 2, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 2, 3, 3, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    // reopen while closing, then extended hold
    add(0, 8'h00, 8'h00, 8'h00, 1, 1, 3, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 4, 3, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 1, 3, 2, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 1, 3, 3, 2, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h08, 8'h00, 8'h00, 0, 1, 3, 2, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 1, 4, 3, 2, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 4, 3, 2, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 5, 3, 3, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 0, 2, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        @(negedge clk);
        rst = tbl[i].rst;
        car_req = tbl[i].car;
        hall_up_req = tbl[i].up;
        hall_down_req = tbl[i].dn;
        door_reopen = tbl[i].ro;
        tick();
        chk($sformatf("tbl%0d.%0d", i, k),
            {current_floor, door_state, move_dir, arrive, dir_up,
             pend_car, pend_up, pend_down},
            {tbl[i].fl, tbl[i].door, tbl[i].mdir, tbl[i].arr, tbl[i].dir,
             tbl[i].pc, tbl[i].pu, tbl[i].pd});
      end
    end
    car_req = '0;
    hall_up_req = '0;
    hall_down_req = '0;
    door_reopen = 1'b0;

    // up hall call at 3 is served on the way to 6
    do_reset();
    car_req = 8'h40;
    tick();
    car_req = '0;
    wait_floor(3'd1, 50, ok);
    chk("t2a_reach1", ok, 1);
    hall_up_req = 8'h08;
    tick();
    hall_up_req = '0;
    wait_arrive(100, ok);
    chk("t2a_arr1", ok, 1);
    chk("t2a_floor3", current_floor, 3);
    chk("t2a_pu", pend_up, 8'h00);
    chk("t2a_pc", pend_car, 8'h40);
    wait_arrive(100, ok);
    chk("t2a_arr2", ok, 1);
    chk("t2a_floor6", current_floor, 6);
    chk("t2a_pc_clr", pend_car, 8'h00);

    // down hall call at 3 is passed going up, served coming down
    do_reset();
    car_req = 8'h40;
    tick();
    car_req = '0;
    wait_floor(3'd1, 50, ok);
    chk("t2b_reach1", ok, 1);
    hall_down_req = 8'h08;
    tick();
    hall_down_req = '0;
    wait_arrive(100, ok);
    chk("t2b_arr1", ok, 1);
    chk("t2b_floor6", current_floor, 6);
    chk("t2b_pd_kept", pend_down, 8'h08);
    chk("t2b_dir", dir_up, 0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (move_dir != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t2b_moves", ok, 1);
    chk("t2b_mdir_down", move_dir, 2'b10);
    wait_arrive(100, ok);
    chk("t2b_arr2", ok, 1);
    chk("t2b_floor3", current_floor, 3);
    chk("t2b_pd_clr", pend_down, 8'h00);

    // reset in the middle of a floor step
    do_reset();
    car_req = 8'h20;
    tick();
    car_req = '0;
    wait_floor(3'd2, 50, ok);
    chk("t5_reach2", ok, 1);
    tick();
    tick();
    chk("t5_moving", move_dir, 2'b01);
    rst = 1'b1;
    car_req = 8'hFF;
    hall_up_req = 8'hFF;
    tick();
    rst = 1'b0;
    car_req = '0;
    hall_up_req = '0;
    chk("t5_state",
        {current_floor, door_state, move_dir, arrive, dir_up,
         pend_car, pend_up, pend_down},
        {3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00});
    tick();
    chk("t5_stay_idle", {move_dir, door_state}, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
